// File: rtl/mbus_master_sleep_ctrl_if.sv
// Bundle of MBus sleep-controller request and control signals.
// The controller uses the slave modport and the surrounding logic uses the master modport.
interface mbus_master_sleep_ctrl_if #(
  parameter int NUM_WAKEUP = 3
);
  logic                  MBUS_DIN;
  logic                  SLEEP_REQ;
  logic [NUM_WAKEUP-1:0] WAKEUP_REQ;
  logic [NUM_WAKEUP-1:0] WAKEUP_MASK;
  logic                  MBC_SLEEP;
  logic                  MBC_SLEEP_B;
  logic                  MBC_ISOLATE;
  logic                  MBC_ISOLATE_B;
  logic                  MBC_RESET;
  logic                  MBC_RESET_B;
  logic                  SYSTEM_ACTIVE;
  logic                  WAKEUP_REQ_ORED;
  logic [NUM_WAKEUP:0]   WAKE_SRC;
  logic [2:0]            STATE;

  modport slave (
    input  MBUS_DIN, SLEEP_REQ, WAKEUP_REQ, WAKEUP_MASK,
    output MBC_SLEEP, MBC_SLEEP_B, MBC_ISOLATE, MBC_ISOLATE_B,
           MBC_RESET, MBC_RESET_B, SYSTEM_ACTIVE, WAKEUP_REQ_ORED,
           WAKE_SRC, STATE
  );

  modport master (
    output MBUS_DIN, SLEEP_REQ, WAKEUP_REQ, WAKEUP_MASK,
    input  MBC_SLEEP, MBC_SLEEP_B, MBC_ISOLATE, MBC_ISOLATE_B,
           MBC_RESET, MBC_RESET_B, SYSTEM_ACTIVE, WAKEUP_REQ_ORED,
           WAKE_SRC, STATE
  );
endinterface

// File: rtl/mbus_master_sleep_ctrl.sv
// MBus master-layer sleep controller: sequences power gate, isolation and layer reset
// with a programmable dwell per phase, and wakes on masked requests or bus activity.
module mbus_master_sleep_ctrl #(
  parameter int NUM_WAKEUP = 3,
  parameter int PWR_DLY    = 1,
  parameter int RST_DLY    = 1,
  parameter int ISO_DLY    = 1,
  parameter int SLP_DLY    = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  mbus_master_sleep_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    ASLEEP = 3'd0,
    PWR_UP = 3'd1,
    UNISO  = 3'd2,
    ACTIVE = 3'd3,
    ISO_ON = 3'd4,
    RST_ON = 3'd5
  } state_t;

  localparam int MAX_A   = (PWR_DLY > RST_DLY) ? PWR_DLY : RST_DLY;
  localparam int MAX_B   = (ISO_DLY > SLP_DLY) ? ISO_DLY : SLP_DLY;
  localparam int MAX_DLY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_DLY + 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [NUM_WAKEUP:0]   r_wakeSrc;
  logic [1:0]            r_sync;
  logic                  r_sleep, r_sleepB, r_iso, r_isoB, r_rst, r_rstB, r_sysActive;

  state_t                w_nextState;
  logic [CW-1:0]         w_nextCnt;
  logic [NUM_WAKEUP:0]   w_nextWakeSrc;
  logic [NUM_WAKEUP-1:0] w_reqMasked;
  logic                  w_ored, w_busWake, w_wake;
  logic                  w_sleepN, w_isoN, w_rstN;

  assign w_reqMasked = bus.WAKEUP_REQ & ~bus.WAKEUP_MASK;
  assign w_ored      = |w_reqMasked;
  assign w_busWake   = ~r_sync[1];
  assign w_wake      = w_ored | (w_busWake & (r_state == ASLEEP));

  // Wake requests take priority over sleep; the powering-up phases ignore both.
  always_comb begin
    w_nextState   = r_state;
    w_nextCnt     = (r_cnt != '0) ? (r_cnt - CW'(1)) : '0;
    w_nextWakeSrc = r_wakeSrc;
    case (r_state)
      ASLEEP: if (w_wake) begin
        w_nextState   = PWR_UP;
        w_nextCnt     = CW'(PWR_DLY - 1);
        w_nextWakeSrc = {w_busWake, w_reqMasked};
      end
      PWR_UP: if (r_cnt == '0) begin
        w_nextState = UNISO;
        w_nextCnt   = CW'(RST_DLY - 1);
      end
      UNISO: if (r_cnt == '0) w_nextState = ACTIVE;
      ACTIVE: if (bus.SLEEP_REQ && !w_ored) begin
        w_nextState = ISO_ON;
        w_nextCnt   = CW'(ISO_DLY - 1);
      end
      ISO_ON: begin
        if (w_ored) begin
          w_nextState = ACTIVE;
        end else if (r_cnt == '0) begin
          w_nextState = RST_ON;
          w_nextCnt   = CW'(SLP_DLY - 1);
        end
      end
      RST_ON: begin
        if (w_ored) begin
          w_nextState = PWR_UP;
          w_nextCnt   = CW'(PWR_DLY - 1);
        end else if (r_cnt == '0) begin
          w_nextState   = ASLEEP;
          w_nextWakeSrc = '0;
        end
      end
      default: w_nextState = ASLEEP;
    endcase
  end

  // Controls are decoded from the next state so the flops track the state register exactly.
  always_comb begin
    w_sleepN = (w_nextState == ASLEEP);
    w_isoN   = (w_nextState inside {ASLEEP, PWR_UP, ISO_ON, RST_ON});
    w_rstN   = (w_nextState inside {ASLEEP, PWR_UP, UNISO, RST_ON});
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ASLEEP;
      r_cnt       <= '0;
      r_wakeSrc   <= '0;
      r_sync      <= 2'b11;
      r_sleep     <= 1'b1;
      r_sleepB    <= 1'b0;
      r_iso       <= 1'b1;
      r_isoB      <= 1'b0;
      r_rst       <= 1'b1;
      r_rstB      <= 1'b0;
      r_sysActive <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_wakeSrc   <= w_nextWakeSrc;
      r_sync      <= {r_sync[0], bus.MBUS_DIN};
      r_sleep     <= w_sleepN;
      r_sleepB    <= ~w_sleepN;
      r_iso       <= w_isoN;
      r_isoB      <= ~w_isoN;
      r_rst       <= w_rstN;
      r_rstB      <= ~w_rstN;
      r_sysActive <= ~(w_sleepN & w_isoN);
    end
  end

  assign bus.MBC_SLEEP       = r_sleep;
  assign bus.MBC_SLEEP_B     = r_sleepB;
  assign bus.MBC_ISOLATE     = r_iso;
  assign bus.MBC_ISOLATE_B   = r_isoB;
  assign bus.MBC_RESET       = r_rst;
  assign bus.MBC_RESET_B     = r_rstB;
  assign bus.SYSTEM_ACTIVE   = r_sysActive;
  assign bus.WAKEUP_REQ_ORED = w_ored;
  assign bus.WAKE_SRC        = r_wakeSrc;
  assign bus.STATE           = r_state;

endmodule

// File: tb/tb_mbus_master_sleep_ctrl.sv
// Scoreboard bench for the MBus sleep controller: a phase/timer reference model pushes
// expected outputs each edge and a negedge monitor pops and compares them.
module tb_mbus_master_sleep_ctrl;

  localparam int NW  = 3;
  localparam int PWR = 3;
  localparam int RST = 2;
  localparam int ISO = 2;
  localparam int SLP = 2;

  typedef struct packed {
    logic [2:0]  phase;
    logic [2:0]  ctrl;
    logic [NW:0] src;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          tbDin, tbSleep;
  logic [NW-1:0] tbReq, tbMask;

  exp_t          expQ[$];
  int            testCount = 0;
  int            failCount = 0;

  int            mPhase, mTimer;
  logic [NW:0]   mSrc;
  logic [1:0]    mSync;

  mbus_master_sleep_ctrl_if #(.NUM_WAKEUP(NW)) bus ();

  assign bus.MBUS_DIN    = tbDin;
  assign bus.SLEEP_REQ   = tbSleep;
  assign bus.WAKEUP_REQ  = tbReq;
  assign bus.WAKEUP_MASK = tbMask;

  mbus_master_sleep_ctrl #(
    .NUM_WAKEUP(NW), .PWR_DLY(PWR), .RST_DLY(RST), .ISO_DLY(ISO), .SLP_DLY(SLP)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // sleep/iso/rst levels for each phase: 0 asleep, 1 power-up, 2 un-isolate, 3 active, 4 iso-on, 5 rst-on
  function automatic logic [2:0] ctrlOf(input int ph);
    case (ph)
      0:       return 3'b111;
      1:       return 3'b011;
      2:       return 3'b001;
      3:       return 3'b000;
      4:       return 3'b010;
      default: return 3'b011;
    endcase
  endfunction

  // Reference model: timer holds the cycles remaining in a timed phase.
  always @(posedge CLK) begin
    exp_t          e;
    logic [NW-1:0] masked;
    logic          ored, bw;
    if (RESET) begin
      mPhase = 0; mTimer = 0; mSrc = '0; mSync = 2'b11;
    end else begin
      masked = tbReq & ~tbMask;
      ored   = |masked;
      bw     = ~mSync[1];
      mSync  = {mSync[0], tbDin};
      case (mPhase)
        0: if (ored || bw) begin mPhase = 1; mTimer = PWR; mSrc = {bw, masked}; end
        1: if (mTimer == 1) begin mPhase = 2; mTimer = RST; end else mTimer--;
        2: if (mTimer == 1) mPhase = 3; else mTimer--;
        3: if (tbSleep && !ored) begin mPhase = 4; mTimer = ISO; end
        4: if (ored) mPhase = 3;
           else if (mTimer == 1) begin mPhase = 5; mTimer = SLP; end
           else mTimer--;
        default: if (ored) begin mPhase = 1; mTimer = PWR; end
                 else if (mTimer == 1) begin mPhase = 0; mSrc = '0; end
                 else mTimer--;
      endcase
    end
    e.phase = 3'(mPhase);
    e.ctrl  = ctrlOf(mPhase);
    e.src   = mSrc;
    expQ.push_back(e);
  end

  task automatic checkOutput(input exp_t e);
    logic [2:0] actCtrl, actCtrlB;
    logic       expOred;
    actCtrl  = {bus.MBC_SLEEP, bus.MBC_ISOLATE, bus.MBC_RESET};
    actCtrlB = {bus.MBC_SLEEP_B, bus.MBC_ISOLATE_B, bus.MBC_RESET_B};
    expOred  = |(tbReq & ~tbMask);
    testCount++;
    if (bus.STATE !== e.phase) begin
      failCount++;
      $display("[TB] FAIL state @%0t: got %0d expected %0d", $time, bus.STATE, e.phase);
    end
    testCount++;
    if (actCtrl !== e.ctrl || actCtrlB !== ~e.ctrl) begin
      failCount++;
      $display("[TB] FAIL ctrl @%0t: got %b/_B %b expected %b/_B %b", $time, actCtrl, actCtrlB, e.ctrl, ~e.ctrl);
    end
    testCount++;
    if (bus.SYSTEM_ACTIVE !== ~(e.ctrl[2] & e.ctrl[1])) begin
      failCount++;
      $display("[TB] FAIL sys_active @%0t: got %b expected %b", $time, bus.SYSTEM_ACTIVE, ~(e.ctrl[2] & e.ctrl[1]));
    end
    testCount++;
    if (bus.WAKE_SRC !== e.src) begin
      failCount++;
      $display("[TB] FAIL wake_src @%0t: got %b expected %b", $time, bus.WAKE_SRC, e.src);
    end
    testCount++;
    if (bus.WAKEUP_REQ_ORED !== expOred) begin
      failCount++;
      $display("[TB] FAIL req_ored @%0t: got %b expected %b", $time, bus.WAKEUP_REQ_ORED, expOred);
    end
  endtask

  always @(negedge CLK) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyStimulus(input logic rst, input logic din, input logic slp,
                               input logic [NW-1:0] req, input logic [NW-1:0] mask, input int n);
    RESET = rst; tbDin = din; tbSleep = slp; tbReq = req; tbMask = mask;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RESET = 1'b1; tbDin = 1'b1; tbSleep = 1'b0; tbReq = '0; tbMask = '0;
    // reset held with all requests high, then wake on release
    applyStimulus(1, 1, 0, 3'b111, 3'b000, 3);
    applyStimulus(0, 1, 0, 3'b111, 3'b000, 1);
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 8);
    // sleep, then wake via request 1
    applyStimulus(0, 1, 1, 3'b000, 3'b000, 8);
    applyStimulus(0, 1, 0, 3'b010, 3'b000, 1);
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 8);
    // sleep, masked request, then bus wake
    applyStimulus(0, 1, 1, 3'b000, 3'b000, 8);
    applyStimulus(0, 1, 0, 3'b100, 3'b100, 1);
    applyStimulus(0, 1, 0, 3'b000, 3'b100, 5);
    applyStimulus(0, 0, 0, 3'b000, 3'b100, 4);
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 8);
    // abort from ISO_ON
    applyStimulus(0, 1, 1, 3'b000, 3'b000, 1);
    applyStimulus(0, 1, 1, 3'b001, 3'b000, 1);
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 3);
    // abort from RST_ON
    applyStimulus(0, 1, 1, 3'b000, 3'b000, 3);
    applyStimulus(0, 1, 0, 3'b001, 3'b000, 1);
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 8);
    // simultaneous sleep and wake in ACTIVE
    applyStimulus(0, 1, 1, 3'b001, 3'b000, 3);
    // reset during UNISO
    applyStimulus(0, 1, 1, 3'b000, 3'b000, 8);
    applyStimulus(0, 1, 0, 3'b001, 3'b000, 1);
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 3);
    applyStimulus(1, 1, 0, 3'b000, 3'b000, 1);
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 3);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic          r, d;
      logic [NW-1:0] q;
      r = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 29) != 0);
      q = ($urandom_range(0, 9) == 0) ? NW'($urandom) : '0;
      if ($urandom_range(0, 7) == 0) tbSleep = ~tbSleep;
      if ($urandom_range(0, 49) == 0) tbMask = NW'($urandom);
      applyStimulus(r, d, tbSleep, q, tbMask, 1);
    end
    applyStimulus(0, 1, 0, 3'b000, 3'b000, 2);
    @(negedge CLK);
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mbus_master_sleep_ctrl.md
# mbus_master_sleep_ctrl

Parametrised MBus master-layer sleep controller. It sequences the power-gate (`MBC_SLEEP`), isolation (`MBC_ISOLATE`) and layer-reset (`MBC_RESET`) controls of the always-on domain. The sleep/wake sequence is a registered state machine with programmable dwell per phase. Wake sources are N maskable requests plus bus activity (`MBUS_DIN` low while asleep), and a sleep sequence can be aborted by a wake request.

## Interface
- `NUM_WAKEUP`, default 3: number of wakeup request inputs, 1..16.
- `PWR_DLY`, default 1: cycles in `PWR_UP`, before isolation release; ≥1.
- `RST_DLY`, default 1: cycles in `UNISO`, before reset release; ≥1.
- `ISO_DLY`, default 1: cycles in `ISO_ON`, before reset assertion; ≥1.
- `SLP_DLY`, default 1: cycles in `RST_ON`, before power gating; ≥1.
- `CLK` in 1: single clock for all flops.
- `RESET` in 1: synchronous, active-high reset.
- `MBUS_DIN` in 1: MBus data line, asynchronous, idle high.
- `SLEEP_REQ` in 1: level request to enter sleep.
- `WAKEUP_REQ` in `NUM_WAKEUP`: level wake requests.
- `WAKEUP_MASK` in `NUM_WAKEUP`: 1 disables the corresponding request.
- `MBC_SLEEP` / `MBC_SLEEP_B` out 1: power-gate control and its complement.
- `MBC_ISOLATE` / `MBC_ISOLATE_B` out 1: isolation control and its complement.
- `MBC_RESET` / `MBC_RESET_B` out 1: layer reset and its complement.
- `SYSTEM_ACTIVE` out 1: equals `~(MBC_SLEEP & MBC_ISOLATE)`.
- `WAKEUP_REQ_ORED` out 1: `|(WAKEUP_REQ & ~WAKEUP_MASK)`, combinational.
- `WAKE_SRC` out `NUM_WAKEUP+1`: latched wake cause; bit `NUM_WAKEUP` is the bus-activity cause.
- `STATE` out 3: current state encoding, for debug.

## Operation
- `MBUS_DIN` passes through a 2-flop synchronizer, giving `din_s`.
- `bus_wake = ~din_s`.
- `wake = WAKEUP_REQ_ORED | (bus_wake & state==ASLEEP)`.
- State encodings, with outputs as sleep/iso/rst:
  - `ASLEEP` 0: 1/1/1.
  - `PWR_UP` 1: 0/1/1.
  - `UNISO` 2: 0/0/1.
  - `ACTIVE` 3: 0/0/0.
  - `ISO_ON` 4: 0/1/0.
  - `RST_ON` 5: 0/1/1.
- Transitions, evaluated each edge:
  - `ASLEEP`: `wake` → `PWR_UP`; on this transition `WAKE_SRC <= {bus_wake, WAKEUP_REQ & ~WAKEUP_MASK}`.
  - `PWR_UP`: after `PWR_DLY` cycles → `UNISO`.
  - `UNISO`: after `RST_DLY` cycles → `ACTIVE`.
  - `ACTIVE`: `SLEEP_REQ & ~WAKEUP_REQ_ORED` → `ISO_ON`; otherwise stay.
  - `ISO_ON`: `WAKEUP_REQ_ORED` → `ACTIVE` (abort). Otherwise, after `ISO_DLY` cycles → `RST_ON`.
  - `RST_ON`: `WAKEUP_REQ_ORED` → `PWR_UP` (abort; counter reloads). Otherwise, after `SLP_DLY` cycles → `ASLEEP`, and `WAKE_SRC <= 0`.
- Wake beats sleep whenever both are present. While in `PWR_UP` or `UNISO`, both `SLEEP_REQ` and wake are ignored.
- If `SLEEP_REQ` is still high when the block reaches `ACTIVE`, it leaves for `ISO_ON` on the next edge.
- Dwell counter:
  - Width is `$clog2(max delay + 1)`.
  - Loaded with `DLY-1` on state entry and decrements each cycle.
  - The phase exits on the edge where the count is 0.
  - Each timed phase therefore lasts exactly its `DLY` cycles.
- All MBC outputs and their `_B` complements are decoded from registered state and driven from flops, with no combinational glitches. `_B` is always the exact complement.
- `RESET` mid-sequence forces `ASLEEP` on the next edge regardless of state, counter or requests. Synchronizer flops reset to 1 (bus idle).

## Timing
- Reset values, while `RESET` is high:
  - `STATE` = 0.
  - `MBC_SLEEP`, `MBC_ISOLATE`, `MBC_RESET` = 1; all `_B` outputs = 0.
  - `SYSTEM_ACTIVE` = 0, `WAKE_SRC` = 0, counter = 0.
- Wakeup-request latency: `WAKEUP_REQ` is sampled at edge t, and `MBC_SLEEP` falls after edge t. `MBC_ISOLATE` falls at t+`PWR_DLY`, and `MBC_RESET` falls at t+`PWR_DLY`+`RST_DLY`.
- Bus-wake latency: 2 synchronizer cycles, plus the 1-cycle state transition, after `MBUS_DIN` falls.
- Sleep latency: `SLEEP_REQ` is sampled at edge t in `ACTIVE`. `MBC_ISOLATE` rises at t, `MBC_RESET` rises at t+`ISO_DLY`, and `MBC_SLEEP` rises at t+`ISO_DLY`+`SLP_DLY`.
- With all delays = 1, each control steps one cycle apart.
- No handshake: requests are levels and must be held until the sequence completes. A single-cycle `WAKEUP_REQ` pulse in `ASLEEP` is sufficient.

## Test plan
- Reset: hold `RESET` 3 cycles with `WAKEUP_REQ`=3'b111 → outputs stay 1/1/1, `SYSTEM_ACTIVE`=0, `WAKE_SRC`=0. Release reset → `PWR_UP` on the next edge.
- Wake via `WAKEUP_REQ[1]` with `PWR_DLY`=3, `RST_DLY`=2 → `MBC_SLEEP` falls at edge t, `MBC_ISOLATE` falls at t+3, `MBC_RESET` falls at t+5, `WAKE_SRC`=4'b0010.
- Masked wake: `WAKEUP_MASK`=3'b100, pulse `WAKEUP_REQ[2]` → stays `ASLEEP`. Then drive `MBUS_DIN`=0 → wake 3 cycles later, `WAKE_SRC`=4'b1000.
- Sleep with `ISO_DLY`=2, `SLP_DLY`=2: `SLEEP_REQ`=1 in `ACTIVE` → `MBC_ISOLATE` rises at t, `MBC_RESET` rises at t+2, `MBC_SLEEP` rises at t+4, `WAKE_SRC` cleared.
- Aborts: `WAKEUP_REQ[0]` during `ISO_ON` → `ACTIVE` next edge, `MBC_RESET` never asserted. `WAKEUP_REQ[0]` during `RST_ON` → `PWR_UP`, `MBC_SLEEP` never asserted.
- Simultaneous `SLEEP_REQ`=1 and `WAKEUP_REQ[0]`=1 in `ACTIVE` → stays `ACTIVE`. `RESET` asserted in `UNISO` → `ASLEEP` next edge.
